// File: rtl/seq_divider.sv
// seq_divider -- iterative restoring divider, one quotient bit per clock.
//
// Computes dividend / divisor in N cycles using a trial subtraction of the
// divisor from the shifted partial remainder. A zero divisor bypasses the
// iteration and completes in one cycle with an all-ones quotient.
//
// Optional build macro: SIGNED_DIV_EN
//   Defined   - operands are two's complement; the core divides magnitudes
//               and the signs are re-applied on completion (truncation toward
//               zero, remainder takes the dividend's sign). overflow flags
//               the -2^(N-1) / -1 case.
//   Undefined - unsigned operands; overflow is constant 0.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        operation request, sampled only while idle
//   dividend     numerator, captured on an accepted start
//   divisor      denominator, captured on an accepted start
//   busy         high while an operation is in progress or completing
//   done         one-cycle pulse when quotient/remainder/flags are updated
//   quotient     registered quotient, held until the next completion
//   remainder    registered remainder, held until the next completion
//   div_by_zero  registered, set with done when the divisor was zero
//   overflow     registered signed-overflow flag
module seq_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  // A restored partial remainder is always below the divisor, so its top
  // bit is always zero; only N bits are stored and the (N+1)-bit value is
  // rebuilt when shifting.
  logic [N-1:0]   rem_r;
  logic [N-1:0]   q_r;
  logic [N-1:0]   dvsr_r;

  logic           accept;
  logic           last;
  logic [N:0]     rem_shift;
  logic [N:0]     trial;
  logic [N-1:0]   rem_next;
  logic [N-1:0]   q_next;
  logic [N-1:0]   q_out;
  logic [N-1:0]   r_out;
  logic [N-1:0]   dvd_in;
  logic [N-1:0]   dvs_in;

`ifdef SIGNED_DIV_EN
  logic           neg_q;
  logic           neg_r;
  logic           ovf_pend;
  logic           ovf_r;

  function automatic logic [N-1:0] negate(input logic signed [N-1:0] v);
    return N'(-v);
  endfunction

  function automatic logic [N-1:0] magnitude(input logic signed [N-1:0] v);
    return v[N-1] ? negate(v) : N'(v);
  endfunction

  // -2^(N-1) has no positive counterpart; its magnitude 2^(N-1) still fits
  // the unsigned N-bit datapath, so the core result is exact.
  assign dvd_in   = magnitude(dividend);
  assign dvs_in   = magnitude(divisor);
  assign q_out    = neg_q ? negate(q_next) : q_next;
  assign r_out    = neg_r ? negate(rem_next) : rem_next;
  assign overflow = ovf_r;
`else
  assign dvd_in   = dividend;
  assign dvs_in   = divisor;
  assign q_out    = q_next;
  assign r_out    = rem_next;
  assign overflow = 1'b0;
`endif

  assign accept    = (state == IDLE) && start;
  assign last      = (cnt == CW'(N - 1));
  assign rem_shift = {rem_r, q_r[N-1]};
  assign trial     = rem_shift - {1'b0, dvsr_r};
  // A clear borrow bit means the divisor fit: keep the difference, emit 1.
  assign rem_next  = trial[N] ? rem_shift[N-1:0] : trial[N-1:0];
  assign q_next    = {q_r[N-2:0], ~trial[N]};

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (divisor == '0) ? DONE : CALC;
      CALC: if (last)  state_nxt = DONE;
      DONE:            state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= '0;
        if (divisor == '0) begin
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
`ifdef SIGNED_DIV_EN
          ovf_r       <= 1'b0;
`endif
        end
      end else if (state == CALC) begin
        cnt <= cnt + CW'(1);
        if (last) begin
          quotient    <= q_out;
          remainder   <= r_out;
          div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
          ovf_r       <= ovf_pend;
`endif
        end
      end
    end
  end

  // Iteration datapath
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_r  <= '0;
      q_r    <= dvd_in;
      dvsr_r <= dvs_in;
`ifdef SIGNED_DIV_EN
      neg_q    <= dividend[N-1] ^ divisor[N-1];
      neg_r    <= dividend[N-1];
      ovf_pend <= (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);
`endif
    end else if (state == CALC) begin
      rem_r <= rem_next;
      q_r   <= q_next;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider -- directed self-checking bench for seq_divider (N = 8).
module tb_seq_divider;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // Issues one operation and waits (bounded) for done. lat is the number of
  // edges after the start edge at which done is first seen (-1 on timeout);
  // busy_n counts samples with busy high up to and including the done cycle.
  // Unless start is held, operands are scrambled after the start edge.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold,
                       output int lat, output int busy_n);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    lat      = -1;
    busy_n   = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (!hold && k == 1) begin
        start    = 1'b0;
        dividend = 8'hA5;
        divisor  = 8'h03;
      end
      if (busy) busy_n++;
      if (done) begin
        lat = k - 1;
        break;
      end
    end
  endtask

  task automatic tick_check_idle(input string tag);
    @(posedge clk); #1;
    check({tag, "_done_low"}, done, 1'b0);
    check({tag, "_busy_low"}, busy, 1'b0);
  endtask

  initial begin
    int lat, busy_n, gap, ndone, first;
    logic [N-1:0] q_cap, r_cap;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_q", quotient, 8'd0);
    check("rst_r", remainder, 8'd0);
    check("rst_dbz", div_by_zero, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // 100 / 7 = 14 r 2; done 8 edges after the start edge, busy for 9 cycles
    do_op(8'd100, 8'd7, 1'b0, lat, busy_n);
    check("a_lat", lat, 8);
    check("a_busy_cycles", busy_n, 9);
    check("a_q", quotient, 8'd14);
    check("a_r", remainder, 8'd2);
    check("a_dbz", div_by_zero, 1'b0);
    check("a_ovf", overflow, 1'b0);
    tick_check_idle("a_after");

    // 255 / 1 then 3 / 200 with start held. After the first done:
    // DONE->IDLE at +1 edge, accepted at +2, done at +2+8 = 10 edges later.
    do_op(8'd255, 8'd1, 1'b1, lat, busy_n);
    check("b1_lat", lat, 8);
    check("b1_q", quotient, 8'd255);
    check("b1_r", remainder, 8'd0);
    dividend = 8'd3;
    divisor  = 8'd200;
    gap = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin gap = k; break; end
    end
    start = 1'b0;
    check("b2_gap", gap, 10);
    check("b2_q", quotient, 8'd0);
    check("b2_r", remainder, 8'd3);
    @(posedge clk); #1;

    // 5 / 0: one-cycle completion
    do_op(8'd5, 8'd0, 1'b0, lat, busy_n);
    check("z_lat", lat, 0);
    check("z_busy_cycles", busy_n, 1);
    check("z_q", quotient, 8'hFF);
    check("z_r", remainder, 8'd5);
    check("z_dbz", div_by_zero, 1'b1);
    tick_check_idle("z_after");
    check("z_hold_q", quotient, 8'hFF);
    check("z_hold_dbz", div_by_zero, 1'b1);
    do_op(8'd100, 8'd7, 1'b0, lat, busy_n);
    check("z2_dbz", div_by_zero, 1'b0);
    check("z2_q", quotient, 8'd14);
    @(posedge clk); #1;

    // start 9/3 pulsed during CALC must be ignored
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    ndone = 0; first = -1; q_cap = '0; r_cap = '0;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      if (k == 3) begin dividend = 8'd9; divisor = 8'd3; start = 1'b1; end
      if (k == 4) start = 1'b0;
      if (done) begin
        ndone++;
        if (first < 0) begin first = k - 1; q_cap = quotient; r_cap = remainder; end
      end
    end
    check("i_ndone", ndone, 1);
    check("i_lat", first, 8);
    check("i_q", q_cap, 8'd14);
    check("i_r", r_cap, 8'd2);

    // async reset mid-operation (results hold 14/2 beforehand)
    do_op(8'd1, 8'd1, 1'b0, lat, busy_n);   // leaves quotient=1, remainder=0
    @(posedge clk); #1;
    do_op(8'd0, 8'd0, 1'b0, lat, busy_n);   // leaves quotient=FF, remainder=0, dbz=1
    @(posedge clk); #1;
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    check("x_busy", busy, 1'b0);
    check("x_done", done, 1'b0);
    check("x_q", quotient, 8'd0);
    check("x_r", remainder, 8'd0);
    check("x_dbz", div_by_zero, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    check("x_no_done", ndone, 0);
    do_op(8'd50, 8'd6, 1'b0, lat, busy_n);
    check("x2_lat", lat, 8);
    check("x2_q", quotient, 8'd8);
    check("x2_r", remainder, 8'd2);
    @(posedge clk); #1;

    // boundaries
    do_op(8'd0, 8'd5, 1'b0, lat, busy_n);
    check("bd_zero_q", quotient, 8'd0);
    check("bd_zero_r", remainder, 8'd0);
    @(posedge clk); #1;
    do_op(8'd255, 8'd255, 1'b0, lat, busy_n);
    check("bd_max_q", quotient, 8'd1);
    check("bd_max_r", remainder, 8'd0);
    @(posedge clk); #1;
    do_op(8'd7, 8'd9, 1'b0, lat, busy_n);
    check("bd_small_q", quotient, 8'd0);
    check("bd_small_r", remainder, 8'd7);
    @(posedge clk); #1;
    do_op(8'd37, 8'd1, 1'b0, lat, busy_n);
    check("bd_one_q", quotient, 8'd37);
    check("bd_one_r", remainder, 8'd0);
    @(posedge clk); #1;

`ifdef SIGNED_DIV_EN
    do_op(8'h9C, 8'd7, 1'b0, lat, busy_n);   // -100 / 7
    check("s1_lat", lat, 8);
    check("s1_q", quotient, 8'hF2);
    check("s1_r", remainder, 8'hFE);
    check("s1_ovf", overflow, 1'b0);
    @(posedge clk); #1;
    do_op(8'd100, 8'hF9, 1'b0, lat, busy_n);  // 100 / -7
    check("s2_q", quotient, 8'hF2);
    check("s2_r", remainder, 8'd2);
    @(posedge clk); #1;
    do_op(8'h80, 8'hFF, 1'b0, lat, busy_n);   // -128 / -1
    check("s3_q", quotient, 8'h80);
    check("s3_r", remainder, 8'd0);
    check("s3_ovf", overflow, 1'b1);
    @(posedge clk); #1;
    do_op(8'hF6, 8'd0, 1'b0, lat, busy_n);    // -10 / 0
    check("s4_q", quotient, 8'hFF);
    check("s4_r", remainder, 8'hF6);
    check("s4_ovf", overflow, 1'b0);
`else
    check("u_ovf", overflow, 1'b0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
